// File: rtl/uart_tx_queue_pkg.sv
// Shared UART status-word bit positions for the IO page, firmware and TX queue.
// Keep in sync with the SOC IO decode constants.
package uart_tx_queue_pkg;

    localparam int UART_STAT_LEVEL_LSB = 0;
    localparam int UART_STAT_EMPTY_bit = 8;
    localparam int UART_STAT_FULL_bit  = 9;
    localparam int UART_STAT_OVF_bit   = 10;
    localparam int UART_STAT_BUSY_bit  = 11;
    localparam int UART_STAT_W         = 32;

endpackage

// File: rtl/uart_tx_queue_sync_fifo_mem.sv
// Byte storage for the UART TX queue.
// Synchronous write port, asynchronous (show-ahead) read port.
module sync_fifo_mem #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue between the IO-page UART data register and the UART emitter.
// Also builds the IO-page UART status word.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  flush,
    input  logic                  clr_overflow,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic [UART_STAT_W-1:0] status
);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  overflow;
    logic                  pop;
    logic                  accept;
    logic                  ovf_set;
    logic                  mem_we;
    logic [7:0]            rd_data;

    // level never exceeds depth, so its MSB alone marks full
    assign full   = level[DEPTH_LOG2];
    assign empty  = (level == '0);
    assign pop    = tx_valid & tx_ready;
    assign accept = push & (!full | pop);
    assign ovf_set = push & full & !pop & !flush;
    assign mem_we = accept & !flush & !reset;

    sync_fifo_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_ptr),
        .wdata(push_data),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : rd_data;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        status = '0;
        status[UART_STAT_LEVEL_LSB +: DEPTH_LOG2+1] = level;
        status[UART_STAT_EMPTY_bit] = empty;
        status[UART_STAT_FULL_bit]  = full;
        status[UART_STAT_OVF_bit]   = overflow;
        status[UART_STAT_BUSY_bit]  = !empty | !tx_ready;
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: vector table for the fill phase,
// scoreboard queue for emitted bytes, hand sequences for corner cases.
module tb_uart_tx_queue;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [7:0]  push_data;
    logic        flush;
    logic        clr_overflow;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [DL2:0] level;
    logic        full;
    logic        empty;
    logic [31:0] status;

    uart_tx_queue #(.DEPTH_LOG2(DL2)) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_data   (push_data),
        .flush       (flush),
        .clr_overflow(clr_overflow),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .status      (status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    logic [7:0] last_pop;
    logic [7:0] sb_q[$];
    logic       m_ovf;

    typedef struct {
        logic        push;
        logic [7:0]  data;
        logic        ready;
        logic        clr;
        logic [4:0]  exp_level;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int sz;
        sz = sb_q.size();
        s = 32'(sz);
        s[8]  = (sz == 0);
        s[9]  = (sz == DEPTH);
        s[10] = m_ovf;
        s[11] = (sz != 0) || !tx_ready;
        return s;
    endfunction

    task automatic check_state(input string tag);
        logic [7:0] exp_d;
        exp_d = (sb_q.size() == 0) ? 8'h00 : sb_q[0];
        check({tag, ".level"}, 32'(level), 32'(sb_q.size()));
        check({tag, ".status"}, status, model_status());
        check({tag, ".tx_valid"}, 32'(tx_valid), 32'(sb_q.size() != 0));
        check({tag, ".tx_data"}, 32'(tx_data), 32'(exp_d));
    endtask

    // One clock: sample handshake before the edge, update scoreboard, settle.
    task automatic tick();
        logic popped;
        logic [7:0] pb;
        logic m_full;
        #1;
        popped = tx_valid & tx_ready;
        pb = tx_data;
        @(posedge clk);
        if (reset) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            m_full = (sb_q.size() == DEPTH);
            if (flush) begin
                sb_q.delete();
            end else begin
                if (popped) begin
                    n_pops++;
                    last_pop = pb;
                    if (sb_q.size() == 0) begin
                        check("pop_unexpected", 32'(pb), 32'hFFFF_FFFF);
                    end else begin
                        check("pop_data", 32'(pb), 32'(sb_q.pop_front()));
                    end
                end
                if (push && (!m_full || popped)) begin
                    sb_q.push_back(push_data);
                end
            end
            if (push && m_full && !popped && !flush) begin
                m_ovf = 1'b1;
            end else if (clr_overflow) begin
                m_ovf = 1'b0;
            end
        end
        #1;
        push = 1'b0;
        flush = 1'b0;
        clr_overflow = 1'b0;
        reset = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        push = 1'b1;
        push_data = d;
        tick();
    endtask

    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && sb_q.size() > 0; k++) begin
            tick();
        end
        check({tag, ".drained"}, 32'(sb_q.size()), 32'd0);
        check({tag, ".empty"}, 32'(empty), 32'd1);
    endtask

    initial begin
        int pops0;
        for (int i = 0; i < 16; i++) begin
            vecs[i].push = 1'b1;
            vecs[i].data = 8'(8'h61 + i);
            vecs[i].ready = 1'b0;
            vecs[i].clr = 1'b0;
            vecs[i].exp_level = 5'(i + 1);
            vecs[i].exp_status = 32'(i + 1) | 32'h800 | ((i == 15) ? 32'h200 : 32'h0);
        end
        vecs[16] = '{1'b1, 8'h71, 1'b0, 1'b0, 5'd16, 32'hE10};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd16, 32'hE10};

        reset = 1'b1;
        push = 1'b0;
        push_data = 8'h00;
        flush = 1'b0;
        clr_overflow = 1'b0;
        tx_ready = 1'b1;
        m_ovf = 1'b0;
        last_pop = 8'h00;
        tick();
        reset = 1'b1;
        tick();
        check("reset.status", status, 32'h100);
        check("reset.tx_valid", 32'(tx_valid), 32'd0);
        check("reset.tx_data", 32'(tx_data), 32'd0);
        check("reset.full", 32'(full), 32'd0);

        for (int i = 0; i < 18; i++) begin
            push = vecs[i].push;
            push_data = vecs[i].data;
            tx_ready = vecs[i].ready;
            clr_overflow = vecs[i].clr;
            tick();
            tx_ready = vecs[i].ready;
            check($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d.status", i), status, vecs[i].exp_status);
        end
        check_state("filled");

        pops0 = n_pops;
        drain("drain1");
        check("drain1.count", 32'(n_pops - pops0), 32'd16);
        check("drain1.last", 32'(last_pop), 32'h70);
        check("drain1.status", status, 32'h500);
        clr_overflow = 1'b1;
        tick();
        check("clr_ovf.status", status, 32'h100);

        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i));
        check("full2.full", 32'(full), 32'd1);
        tx_ready = 1'b1;
        push = 1'b1;
        push_data = 8'h41;
        tick();
        check("pushpop.level", 32'(level), 32'd16);
        check("pushpop.status", status, 32'hA10);
        check_state("pushpop");
        pops0 = n_pops;
        drain("drain2");
        check("drain2.count", 32'(n_pops - pops0), 32'd16);
        check("drain2.last", 32'(last_pop), 32'h41);

        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'(8'hA0 + i));
        check("pre_flush.level", 32'(level), 32'd3);
        flush = 1'b1;
        push = 1'b1;
        push_data = 8'h55;
        tick();
        check("flush.level", 32'(level), 32'd0);
        check("flush.tx_valid", 32'(tx_valid), 32'd0);
        tx_ready = 1'b1;
        pops0 = n_pops;
        for (int k = 0; k < 4; k++) tick();
        check("flush.no_pops", 32'(n_pops - pops0), 32'd0);

        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'(8'hC0 + i));
        check("ovf2.status", status, 32'hE10);
        tx_ready = 1'b1;
        tick();
        tick();
        check_state("mid_drain");
        reset = 1'b1;
        tick();
        check("rst_mid.level", 32'(level), 32'd0);
        check("rst_mid.empty", 32'(empty), 32'd1);
        check("rst_mid.ovf", 32'(status[10]), 32'd0);
        tx_ready = 1'b0;
        push_byte(8'h0D);
        check("latency.tx_valid", 32'(tx_valid), 32'd1);
        check("latency.tx_data", 32'(tx_data), 32'h0D);
        check_state("final");
        drain("drain3");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
